// File: rtl/global_defs.sv
// Global MPU defaults shared by the datapath blocks.
package global_defs;

  localparam int FP               = 32;
  localparam int M                = 4;
  localparam int N                = 4;
  localparam int MATRIX_REGISTERS = 4;

endpackage

// File: rtl/mpu_pkg.sv
// MPU shared types: state encoding of the matrix register file store FSM.
package mpu_pkg;

  typedef enum logic {
    RF_IDLE   = 1'b0,
    RF_STREAM = 1'b1
  } regfile_st_state_t;

endpackage

// File: rtl/mpu_regfile_rowmajor_ctr.sv
// Row-major (i, j) walker for a matrix of m_size x n_size elements.
// load restarts at (0,0) with new sizes, advance steps to the next element,
// last flags the final element. next_i/next_j expose the following
// coordinate so the caller can fetch data on the same edge it advances.
module mpu_regfile_rowmajor_ctr #(
  parameter int IW  = 2,
  parameter int JW  = 2,
  parameter int SMW = 3,
  parameter int SNW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           advance,
  input  logic [SMW-1:0] m_size_in,
  input  logic [SNW-1:0] n_size_in,
  output logic [IW-1:0]  i_out,
  output logic [JW-1:0]  j_out,
  output logic [SMW-1:0] m_size_out,
  output logic [SNW-1:0] n_size_out,
  output logic [IW-1:0]  next_i_out,
  output logic [JW-1:0]  next_j_out,
  output logic           last_out
);

  logic [IW-1:0]  i_q;
  logic [JW-1:0]  j_q;
  logic [SMW-1:0] m_q;
  logic [SNW-1:0] n_q;
  logic           last_row;
  logic           last_col;

  // Next coordinate and end-of-row / end-of-matrix detection.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    last_row   = (SMW'(i_q) == m_q - SMW'(1));
    last_col   = (SNW'(j_q) == n_q - SNW'(1));
    next_i_out = i_q;
    next_j_out = j_q + JW'(1);
    if (last_col) begin
      next_j_out = '0;
      next_i_out = i_q + IW'(1);
    end
  end

  // Coordinate and size registers.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
      m_q <= '0;
      n_q <= '0;
    end else if (load) begin
      i_q <= '0;
      j_q <= '0;
      m_q <= m_size_in;
      n_q <= n_size_in;
    end else if (advance) begin
      i_q <= next_i_out;
      j_q <= next_j_out;
    end
  end

  assign i_out      = i_q;
  assign j_out      = j_q;
  assign m_size_out = m_q;
  assign n_size_out = n_q;
  assign last_out   = last_row && last_col;

endmodule

// File: rtl/mpu_matrix_regfile.sv
// MPU matrix register file: REGS matrices of up to M x N elements, element
// writes over a load handshake, whole-register row-major streaming over a
// store handshake. Each register keeps its own row/column sizes.
// Optional feature: define MPU_REGFILE_BOUNDS_CHECK_EN to drop out-of-range
// loads and report them (and streams of unloaded registers) on err_out.
import mpu_pkg::*;

module mpu_matrix_regfile #(
  parameter  int FP   = global_defs::FP,
  parameter  int M    = global_defs::M,
  parameter  int N    = global_defs::N,
  parameter  int REGS = global_defs::MATRIX_REGISTERS,
  localparam int AW   = $clog2(REGS),
  localparam int IW   = $clog2(M),
  localparam int JW   = $clog2(N),
  localparam int SMW  = $clog2(M + 1),
  localparam int SNW  = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld_valid_in,
  output logic           ld_ready_out,
  input  logic [AW-1:0]  ld_addr_in,
  input  logic [IW-1:0]  ld_i_in,
  input  logic [JW-1:0]  ld_j_in,
  input  logic [SMW-1:0] ld_m_size_in,
  input  logic [SNW-1:0] ld_n_size_in,
  input  logic [FP-1:0]  ld_data_in,
  input  logic           st_req_in,
  input  logic [AW-1:0]  st_addr_in,
  output logic           st_busy_out,
  output logic           st_valid_out,
  input  logic           st_ready_in,
  output logic [FP-1:0]  st_data_out,
  output logic [IW-1:0]  st_i_out,
  output logic [JW-1:0]  st_j_out,
  output logic [SMW-1:0] st_m_size_out,
  output logic [SNW-1:0] st_n_size_out,
  output logic           st_last_out,
  output logic           err_out
);

  regfile_st_state_t state_q, state_d;

  logic [FP-1:0]   mem [REGS][M][N];
  logic [SMW-1:0]  m_size_q [REGS];
  logic [SNW-1:0]  n_size_q [REGS];
  logic [REGS-1:0] loaded_q;

  logic [AW-1:0]   st_addr_q;
  logic [FP-1:0]   st_data_q;

  logic            idle;
  logic            streaming;
  logic            ld_accept;
  logic            ld_ok;
  logic            ld_commit;
  logic            req_loaded;
  logic            start;
  logic            ctr_advance;
  logic            ctr_last;
  logic [SMW-1:0]  start_m;
  logic [SNW-1:0]  start_n;
  logic [IW-1:0]   next_i;
  logic [JW-1:0]   next_j;

  assign idle      = (state_q == RF_IDLE);
  assign streaming = (state_q == RF_STREAM);

  // A stream owns its register; a same-cycle stream request beats a load.
  assign ld_ready_out = !rst
                        && !(streaming && (ld_addr_in == st_addr_q))
                        && !(idle && st_req_in && (st_addr_in == ld_addr_in));
  assign ld_accept    = ld_valid_in && ld_ready_out;

`ifdef MPU_REGFILE_BOUNDS_CHECK_EN
  // Zero sizes fall out of the index comparisons (nothing is below zero).
  assign ld_ok = (SMW'(ld_i_in) < ld_m_size_in)
                 && (SNW'(ld_j_in) < ld_n_size_in)
                 && (ld_m_size_in <= SMW'(M))
                 && (ld_n_size_in <= SNW'(N));
`else
  assign ld_ok = 1'b1;
`endif

  assign ld_commit = ld_accept && ld_ok;

  assign req_loaded = loaded_q[st_addr_in];
  assign start      = idle && st_req_in && req_loaded
                      && (m_size_q[st_addr_in] != '0)
                      && (n_size_q[st_addr_in] != '0);

  // Sizes above the array bound (only reachable without bounds checking)
  // are clamped so the walker always terminates.
  assign start_m = (m_size_q[st_addr_in] > SMW'(M)) ? SMW'(M) : m_size_q[st_addr_in];
  assign start_n = (n_size_q[st_addr_in] > SNW'(N)) ? SNW'(N) : n_size_q[st_addr_in];

  assign ctr_advance = streaming && st_ready_in && !ctr_last;

  // Store FSM next-state: idle until a valid request, stream until last handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RF_IDLE:   if (start) state_d = RF_STREAM;
      RF_STREAM: if (st_ready_in && ctr_last) state_d = RF_IDLE;
      default:   state_d = RF_IDLE;
    endcase
  end

  // Store FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RF_IDLE;
    else     state_q <= state_d;
  end

  mpu_regfile_rowmajor_ctr #(
    .IW  (IW),
    .JW  (JW),
    .SMW (SMW),
    .SNW (SNW)
  ) u_ctr (
    .clk        (clk),
    .rst        (rst),
    .load       (start),
    .advance    (ctr_advance),
    .m_size_in  (start_m),
    .n_size_in  (start_n),
    .i_out      (st_i_out),
    .j_out      (st_j_out),
    .m_size_out (st_m_size_out),
    .n_size_out (st_n_size_out),
    .next_i_out (next_i),
    .next_j_out (next_j),
    .last_out   (ctr_last)
  );

  // Output element register and streamed-register address snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_addr_q <= '0;
      st_data_q <= '0;
    end else if (start) begin
      st_addr_q <= st_addr_in;
      st_data_q <= mem[st_addr_in][0][0];
    end else if (ctr_advance) begin
      st_data_q <= mem[st_addr_q][next_i][next_j];
    end
  end

  // Element storage.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; only the loaded bits and sizes are, which gate every read.
    if (ld_commit) mem[ld_addr_in][ld_i_in][ld_j_in] <= ld_data_in;
  end

  // Per-register size pair and loaded flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      loaded_q <= '0;
      for (int r = 0; r < REGS; r++) begin
        m_size_q[r] <= '0;
        n_size_q[r] <= '0;
      end
    end else if (ld_commit) begin
      loaded_q[ld_addr_in] <= 1'b1;
      m_size_q[ld_addr_in] <= ld_m_size_in;
      n_size_q[ld_addr_in] <= ld_n_size_in;
    end
  end

`ifdef MPU_REGFILE_BOUNDS_CHECK_EN
  logic err_q;

  // Sticky error: rejected load or stream request on an unloaded register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((ld_accept && !ld_ok) || (idle && st_req_in && !req_loaded)) begin
      err_q <= 1'b1;
    end
  end

  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

  assign st_busy_out  = streaming;
  assign st_valid_out = streaming;
  assign st_data_out  = st_data_q;
  assign st_last_out  = streaming && ctr_last;

endmodule

// File: tb/tb_mpu_matrix_regfile.sv
// Self-checking bench for mpu_matrix_regfile: table-driven loads, directed
// stream corner cases, and randomized loads/streams against an array model.
module tb_mpu_matrix_regfile;

  localparam int FP   = 32;
  localparam int M    = 4;
  localparam int N    = 4;
  localparam int REGS = 4;
  localparam int AW   = 2;
  localparam int IW   = 2;
  localparam int JW   = 2;
  localparam int SMW  = 3;
  localparam int SNW  = 3;

  logic           clk;
  logic           rst;
  logic           ld_valid_in;
  logic           ld_ready_out;
  logic [AW-1:0]  ld_addr_in;
  logic [IW-1:0]  ld_i_in;
  logic [JW-1:0]  ld_j_in;
  logic [SMW-1:0] ld_m_size_in;
  logic [SNW-1:0] ld_n_size_in;
  logic [FP-1:0]  ld_data_in;
  logic           st_req_in;
  logic [AW-1:0]  st_addr_in;
  logic           st_busy_out;
  logic           st_valid_out;
  logic           st_ready_in;
  logic [FP-1:0]  st_data_out;
  logic [IW-1:0]  st_i_out;
  logic [JW-1:0]  st_j_out;
  logic [SMW-1:0] st_m_size_out;
  logic [SNW-1:0] st_n_size_out;
  logic           st_last_out;
  logic           err_out;

  mpu_matrix_regfile #(.FP(FP), .M(M), .N(N), .REGS(REGS)) dut (
    .clk           (clk),
    .rst           (rst),
    .ld_valid_in   (ld_valid_in),
    .ld_ready_out  (ld_ready_out),
    .ld_addr_in    (ld_addr_in),
    .ld_i_in       (ld_i_in),
    .ld_j_in       (ld_j_in),
    .ld_m_size_in  (ld_m_size_in),
    .ld_n_size_in  (ld_n_size_in),
    .ld_data_in    (ld_data_in),
    .st_req_in     (st_req_in),
    .st_addr_in    (st_addr_in),
    .st_busy_out   (st_busy_out),
    .st_valid_out  (st_valid_out),
    .st_ready_in   (st_ready_in),
    .st_data_out   (st_data_out),
    .st_i_out      (st_i_out),
    .st_j_out      (st_j_out),
    .st_m_size_out (st_m_size_out),
    .st_n_size_out (st_n_size_out),
    .st_last_out   (st_last_out),
    .err_out       (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: plain arrays holding what the register file should contain.
  logic [FP-1:0] mdl_mem [REGS][M][N];
  int            mdl_m [REGS];
  int            mdl_n [REGS];
  bit            mdl_loaded [REGS];
  bit            mdl_err;

  typedef struct {
    int          addr;
    int          i;
    int          j;
    int          m;
    int          n;
    logic [31:0] data;
    bit          exp_ready;
  } ld_vec_t;

  ld_vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int r = 0; r < REGS; r++) begin
      mdl_m[r]      = 0;
      mdl_n[r]      = 0;
      mdl_loaded[r] = 0;
    end
    mdl_err = 0;
  endtask

  task automatic model_apply(input int a, input int i, input int j, input int m, input int n,
                             input logic [FP-1:0] d);
    bit bad;
    bad = (i >= m) || (j >= n) || (m > M) || (n > N) || (m == 0) || (n == 0);
`ifdef MPU_REGFILE_BOUNDS_CHECK_EN
    if (bad) begin
      mdl_err = 1;
      return;
    end
`else
    if (bad) begin end
`endif
    mdl_mem[a][i][j] = d;
    mdl_m[a]         = m;
    mdl_n[a]         = n;
    mdl_loaded[a]    = 1;
  endtask

  // One load attempt; ready is checked against the expectation before the edge.
  task automatic do_load(input int a, input int i, input int j, input int m, input int n,
                         input logic [FP-1:0] d, input bit exp_ready, input string name);
    ld_valid_in  = 1'b1;
    ld_addr_in   = AW'(a);
    ld_i_in      = IW'(i);
    ld_j_in      = JW'(j);
    ld_m_size_in = SMW'(m);
    ld_n_size_in = SNW'(n);
    ld_data_in   = d;
    #1;
    check({name, " ld_ready"}, ld_ready_out, exp_ready);
    tick();
    ld_valid_in = 1'b0;
    if (exp_ready) model_apply(a, i, j, m, n, d);
  endtask

  // Consume the whole stream of register a. mode 0: ready high, 1: 1,0,0,1 pattern, 2: random.
  // Ends in the cycle busy should have dropped.
  task automatic drain(input int a, input int mode, input string tag);
    int em, en, total, idx, cyc, budget, ei, ej;
    bit r;
    em = mdl_m[a];
    en = mdl_n[a];
    total = em * en;
    idx = 0;
    cyc = 0;
    budget = total * 8 + 16;
    while (idx < total && cyc < budget) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      st_ready_in = r;
      #1;
      ei = idx / en;
      ej = idx % en;
      check({tag, " valid"}, st_valid_out, 1);
      check({tag, " data"},  st_data_out, mdl_mem[a][ei][ej]);
      check({tag, " i"},     st_i_out, ei);
      check({tag, " j"},     st_j_out, ej);
      check({tag, " m_size"}, st_m_size_out, em);
      check({tag, " n_size"}, st_n_size_out, en);
      check({tag, " last"},  st_last_out, (idx == total - 1));
      tick();
      if (r) idx++;
      cyc++;
    end
    if (idx != total) check({tag, " beat count (timeout)"}, idx, total);
    st_ready_in = 1'b0;
    check({tag, " busy after last"},  st_busy_out, 0);
    check({tag, " valid after last"}, st_valid_out, 0);
  endtask

  task automatic run_stream(input int a, input int mode, input string tag);
    bit go;
    go = mdl_loaded[a] && (mdl_m[a] > 0) && (mdl_n[a] > 0);
    st_addr_in = AW'(a);
    st_req_in  = 1'b1;
    tick();
    st_req_in = 1'b0;
`ifdef MPU_REGFILE_BOUNDS_CHECK_EN
    if (!mdl_loaded[a]) mdl_err = 1;
`endif
    if (go) begin
      check({tag, " busy at T+1"}, st_busy_out, 1);
      drain(a, mode, tag);
    end else begin
      check({tag, " no beat busy"},  st_busy_out, 0);
      check({tag, " no beat valid"}, st_valid_out, 0);
      check({tag, " err"},           err_out, mdl_err);
      tick();
      check({tag, " still idle"},    st_busy_out, 0);
    end
  endtask

  initial begin
    rst          = 1'b1;
    ld_valid_in  = 1'b0;
    ld_addr_in   = '0;
    ld_i_in      = '0;
    ld_j_in      = '0;
    ld_m_size_in = '0;
    ld_n_size_in = '0;
    ld_data_in   = '0;
    st_req_in    = 1'b0;
    st_addr_in   = '0;
    st_ready_in  = 1'b0;
    model_reset();

    // Table: reg2 as 2x3 holding 1..6, then reg1 as 1x2.
    for (int k = 0; k < 6; k++)
      tbl[k] = '{addr: 2, i: k / 3, j: k % 3, m: 2, n: 3, data: 32'(k + 1), exp_ready: 1'b1};
    tbl[6] = '{addr: 1, i: 0, j: 0, m: 1, n: 2, data: 32'h0000_A001, exp_ready: 1'b1};
    tbl[7] = '{addr: 1, i: 0, j: 1, m: 1, n: 2, data: 32'h0000_A002, exp_ready: 1'b1};

    repeat (2) tick();
    check("reset busy",     st_busy_out, 0);
    check("reset valid",    st_valid_out, 0);
    check("reset last",     st_last_out, 0);
    check("reset data",     st_data_out, 0);
    check("reset i",        st_i_out, 0);
    check("reset j",        st_j_out, 0);
    check("reset m_size",   st_m_size_out, 0);
    check("reset n_size",   st_n_size_out, 0);
    check("reset err",      err_out, 0);
    check("reset ld_ready", ld_ready_out, 0);
    rst = 1'b0;

    // Fill every element of every register as M x N so later reads are known.
    for (int r = 0; r < REGS; r++)
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++)
          do_load(r, i, j, M, N, $urandom, 1'b1, "init");

    foreach (tbl[k])
      do_load(tbl[k].addr, tbl[k].i, tbl[k].j, tbl[k].m, tbl[k].n, tbl[k].data,
              tbl[k].exp_ready, "table");

    run_stream(2, 0, "basic");
    run_stream(2, 1, "backpressure");

    // Independent sizes; second request lands in the cycle busy drops.
    run_stream(1, 0, "reg1 1x2");
    run_stream(0, 0, "reg0 4x4 b2b");

    // Collision: stalled stream on reg1 blocks reg1 loads, reg3 loads proceed.
    st_addr_in = 1;
    st_req_in  = 1'b1;
    tick();
    st_req_in   = 1'b0;
    st_ready_in = 1'b0;
    check("collide busy", st_busy_out, 1);
    do_load(1, 0, 0, mdl_m[1], mdl_n[1], 32'hBAD0_0001, 1'b0, "collide same reg");
    do_load(3, 1, 1, mdl_m[3], mdl_n[3], 32'h3333_1111, 1'b1, "collide other reg");
    drain(1, 0, "collide stream");

    // Request and load to the same register in one cycle: the stream wins.
    st_addr_in   = 2;
    st_req_in    = 1'b1;
    ld_valid_in  = 1'b1;
    ld_addr_in   = 2;
    ld_i_in      = 0;
    ld_j_in      = 0;
    ld_m_size_in = 3'(mdl_m[2]);
    ld_n_size_in = 3'(mdl_n[2]);
    ld_data_in   = 32'hBAD0_0002;
    #1;
    check("same-cycle ld_ready", ld_ready_out, 0);
    tick();
    st_req_in = 1'b0;
    #1;
    check("same-cycle busy",          st_busy_out, 1);
    check("same-cycle ld_ready busy", ld_ready_out, 0);
    ld_valid_in = 1'b0;
    tick();
    drain(2, 0, "same-cycle stream");

    // Out-of-range row index.
    do_load(3, 3, 0, 2, 2, 32'hDEAD_BEEF, 1'b1, "bounds");
    check("bounds err", err_out, mdl_err);
`ifndef MPU_REGFILE_BOUNDS_CHECK_EN
    check("bounds err tied low", err_out, 0);
`endif
    run_stream(3, 0, "bounds stream");

    // Reset at beat 3 of a 4x4 stream.
    st_addr_in = 0;
    st_req_in  = 1'b1;
    tick();
    st_req_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      st_ready_in = 1'b1;
      #1;
      check("pre-reset data", st_data_out, mdl_mem[0][0][k]);
      tick();
    end
    rst = 1'b1;
    #1;
    check("midrst ld_ready", ld_ready_out, 0);
    tick();
    rst         = 1'b0;
    st_ready_in = 1'b0;
    model_reset();
    check("midrst busy",   st_busy_out, 0);
    check("midrst valid",  st_valid_out, 0);
    check("midrst last",   st_last_out, 0);
    check("midrst data",   st_data_out, 0);
    check("midrst i",      st_i_out, 0);
    check("midrst j",      st_j_out, 0);
    check("midrst m_size", st_m_size_out, 0);
    check("midrst n_size", st_n_size_out, 0);
    check("midrst err",    err_out, 0);
    run_stream(0, 0, "post-reset unloaded");

    // Randomized phase: fresh sizes per register, random streams with random ready.
    for (int r = 0; r < REGS; r++) begin
      int m, n;
      m = $urandom_range(1, M);
      n = $urandom_range(1, N);
      for (int i = 0; i < m; i++)
        for (int j = 0; j < n; j++)
          do_load(r, i, j, m, n, $urandom, 1'b1, "rand fill");
    end
    for (int t = 0; t < 8; t++) begin
      int a;
      a = $urandom_range(0, REGS - 1);
      do_load(a, $urandom_range(0, mdl_m[a] - 1), $urandom_range(0, mdl_n[a] - 1),
              mdl_m[a], mdl_n[a], $urandom, 1'b1, "rand update");
      run_stream(a, 2, "rand stream");
    end

    check("final err", err_out, mdl_err);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mpu_matrix_regfile.md
# mpu_matrix_regfile

Parametrised matrix register file for the MPU, sitting between the memory load/store sequencers and the compute array. It holds `REGS` matrices of up to `M`×`N` elements each, accepts element writes over a valid/ready handshake, and streams a whole register out in row-major order under a valid/ready handshake. Row and column sizes are tracked independently per register, not globally.

## Interface
Parameters:
- `FP`, 32, element width in bits
- `M`, 4, maximum rows per register
- `N`, 4, maximum columns per register
- `REGS`, 4, number of matrix registers

Derived widths:
- `AW` = $clog2(REGS)
- `IW` = $clog2(M), `JW` = $clog2(N)
- `SMW` = $clog2(M+1), `SNW` = $clog2(N+1)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous reset, active high
- `ld_valid_in`  in  1  load element valid
- `ld_ready_out`  out  1  load element accepted when high with valid
- `ld_addr_in`  in  AW  target register
- `ld_i_in` / `ld_j_in`  in  IW / JW  element row / column
- `ld_m_size_in` / `ld_n_size_in`  in  SMW / SNW  matrix rows / columns
- `ld_data_in`  in  FP  element data
- `st_req_in`  in  1  start streaming a register (single-cycle pulse)
- `st_addr_in`  in  AW  register to stream
- `st_busy_out`  out  1  stream in progress
- `st_valid_out`  out  1  output element valid
- `st_ready_in`  in  1  consumer ready
- `st_data_out`  out  FP  element data
- `st_i_out` / `st_j_out`  out  IW / JW  element coordinates
- `st_m_size_out` / `st_n_size_out`  out  SMW / SNW  sizes of the streamed register
- `st_last_out`  out  1  final element of the stream
- `err_out`  out  1  sticky error; see Configuration

## Operation
- Load accept = `ld_valid_in && ld_ready_out`. On accept:
  - write `ld_data_in` to `[ld_addr_in][ld_i_in][ld_j_in]`
  - set that register's size pair to `ld_m_size_in` / `ld_n_size_in`
  - set its `loaded` bit
- `ld_ready_out` is combinational. It is low when any of these holds:
  - `rst` is high
  - `st_busy_out` is high and `ld_addr_in` equals the streaming register
  - in IDLE, `st_req_in` is high and `st_addr_in == ld_addr_in` (the stream wins)
- Loads to any other register proceed during a stream.
- Store FSM (`mpu_pkg::regfile_st_state_t`): `RF_IDLE`, `RF_STREAM`.
  - **RF_IDLE:** `st_req_in` with the target register loaded and sizes nonzero:
    - snapshot register address and sizes
    - load element (0,0) into the output register
    - go to `RF_STREAM`
  - **RF_IDLE, other cases:** `st_req_in` on an unloaded or zero-size register produces no beats and the FSM stays in IDLE.
  - **RF_STREAM:** output held stable while `st_valid_out && !st_ready_in`.
    - On handshake, the next element in row-major order (j increments; wraps to 0 at `n_size-1` with i incrementing) is loaded into the output register on the same edge, giving one beat per cycle.
    - `st_last_out` is high when i = m_size-1 and j = n_size-1.
    - Handshake on the last beat returns the FSM to IDLE.
  - `st_req_in` while busy is ignored.
- Reset values: `st_busy_out`, `st_valid_out` and `st_last_out` = 0; `st_data_out`, `st_i_out`, `st_j_out`, `st_m_size_out` and `st_n_size_out` = 0; `err_out` = 0. All size pairs and `loaded` bits are cleared. Array contents are not reset.

## Timing
- Load: write is visible to a stream that starts the cycle after the accept.
- Store: `st_req_in` at cycle T gives `st_busy_out` and `st_valid_out` high at T+1 with element (0,0).
- A full m×n stream with `st_ready_in` held high takes m·n cycles. `st_busy_out` drops the cycle after the last handshake.
- Back-to-back: `st_req_in` in the cycle `st_busy_out` goes low is accepted.
- `rst` mid-stream forces IDLE on the next edge. The partial stream is abandoned and there is no `st_last_out`.

## Configuration
- `MPU_REGFILE_BOUNDS_CHECK_EN` defined:
  - A load with `ld_i_in >= ld_m_size_in`, `ld_j_in >= ld_n_size_in`, size greater than M/N, or size zero is still accepted (ready unaffected).
  - The data is dropped, the sizes are unchanged, and `err_out` is set.
  - `st_req_in` on an unloaded register also sets `err_out`.
  - `err_out` stays set until `rst`.
- Undefined:
  - No checks; out-of-range indices write using the truncated index bits.
  - `err_out` is tied 0.

## Structure
- `mpu_pkg`: `regfile_st_state_t`.
- `global_defs`: `FP`, `M`, `N` and `MATRIX_REGISTERS`, which are the defaults for the parameters.
- One sub-module, `mpu_regfile_rowmajor_ctr`: i/j counter with load, advance and `last` output, parameterised by IW/JW/SMW/SNW.

## Test plan
- **Basic stream:** load register 2 as 2×3 with values 1..6, then `st_req` addr 2 with ready held high → six beats at T+1..T+6, data 1..6, (i,j) from (0,0) to (1,2), `st_last` on beat 6, busy low at T+7.
- **Backpressure:** same stream with `st_ready_in` toggling 1,0,0,1… → data and coordinates stable while stalled; no beats lost or duplicated.
- **Independent sizes:** reg0 is 4×4 and reg1 is 1×2 → streaming reg1 gives 2 beats reporting sizes 1/2; reg0 still streams 16 beats.
- **Collision:** while reg1 streams, a load to reg1 sees `ld_ready_out`=0 and a load to reg3 is accepted. `st_req` and a load to the same reg in the same cycle → the stream starts and the load stalls.
- **Reset mid-stream:** `rst` at beat 3 of 16 → next cycle busy, valid and all outputs are 0. Then `st_req` on the same register → no beats (unloaded).
- **Bounds check (macro on):** load i=3 with m_size=2 → `err_out`=1 and the element is not written. With the macro off, `err_out` stays 0.
